// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported memory (req/ack handshake) between the MIPS core's
//   fetch port and memory-stage data port. Instructions and data live in one
//   unified memory. Per-port stall outputs feed the hazard unit's global stall.
//
//   Optional feature: define ARB_TIMEOUT_EN to abort an access that has waited
//   TIMEOUT mem_req cycles without mem_ack (sets sticky err, returns rdata=0).
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  busy cycles without ack before abort (ARB_TIMEOUT_EN only)
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   i_req/i_addr               fetch request/address (held while i_stall=1)
//   i_rdata/i_stall            fetched word, fetch-not-yet-serviced
//   d_req/d_we/d_addr/d_wdata  data request, 1=store, address, store data
//   d_rdata/d_stall            load data, data-not-yet-serviced
//   mem_req/mem_we             memory request (held until ack), write enable
//   mem_addr/mem_wdata         memory address, write data
//   mem_rdata/mem_ack          memory read data, one-cycle completion pulse
//   err                        sticky timeout flag (0 without ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_DONE,
    D_DONE
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_d;
  logic   w_grant_d;
  logic   w_grant_i;
  logic   w_busy;
  logic   w_timeout;
  logic   w_finish;

  assign w_busy   = (r_state == I_BUSY) || (r_state == D_BUSY);
  assign w_finish = w_busy && (mem_ack || w_timeout);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_timeout = w_busy && !mem_ack && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_busy && !mem_ack && !w_timeout) r_cnt <= r_cnt + CW'(1);
      else                                  r_cnt <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Data normally wins (older instruction); right after a data grant a
  // pending fetch wins once so the fetch port cannot starve.
  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (d_req && (!i_req || !r_last_d)) begin
          w_next    = D_BUSY;
          w_grant_d = 1'b1;
        end else if (i_req) begin
          w_next    = I_BUSY;
          w_grant_i = 1'b1;
        end
      end
      I_BUSY:  if (mem_ack || w_timeout) w_next = I_DONE;
      D_BUSY:  if (mem_ack || w_timeout) w_next = D_DONE;
      I_DONE:  w_next = IDLE;
      D_DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      r_last_d  <= 1'b0;
    end else begin
      if (w_grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        r_last_d  <= 1'b1;
      end else if (w_grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        r_last_d  <= 1'b0;
      end else if (w_finish) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      // An aborted access returns zero so the pipeline sees a defined value.
      if (r_state == I_BUSY) begin
        if (mem_ack)        i_rdata <= mem_rdata;
        else if (w_timeout) i_rdata <= '0;
      end
      if (r_state == D_BUSY) begin
        if (mem_ack && !mem_we) d_rdata <= mem_rdata;
        else if (w_timeout)     d_rdata <= '0;
      end
    end
  end

  assign i_stall = i_req && (r_state != I_DONE);
  assign d_stall = d_req && (r_state != D_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_stall;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack   = 1'b0;
  logic          err;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory backing store seen through the DUT, and the bench's own view of it.
  logic [31:0] mem_arr [0:511];
  logic [31:0] ref_mem [0:511];

  // Memory responder: acks rsp_delay cycles after mem_req is first seen
  // (rsp_delay < 0 means random 0..3); optionally pulses stray acks when idle.
  int rsp_delay = 0;
  bit rsp_en    = 1'b1;
  bit spur_ack  = 1'b0;
  int wcnt      = 0;
  bit in_txn    = 1'b0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req && rsp_en) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        wcnt   = (rsp_delay < 0) ? int'($urandom_range(3, 0)) : rsp_delay;
      end
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_arr[mem_addr[10:2]];
        if (mem_we) mem_arr[mem_addr[10:2]] = mem_wdata;
        in_txn    = 1'b0;
      end else begin
        wcnt--;
      end
    end else if (!mem_req) begin
      in_txn = 1'b0;
      if (spur_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Grant monitor: every rising mem_req is one grant; data lives at >= 0x100.
  logic [31:0] grant_q [$];
  int          d_grants = 0;
  logic        prev_req = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mem_req && !prev_req) begin
      grant_q.push_back(mem_addr);
      if (mem_addr >= 32'h100) d_grants++;
    end
    prev_req = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_i;
  logic [31:0] exp_d;
  int          dn;
  bit          idone;
  int          i_wait, d_wait, i_snap;

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 512; k++) mem_arr[k] = $urandom;
    mem_arr[16] = 32'h2008_0005;   // 0x40
    mem_arr[17] = 32'h1111_0002;   // 0x44
    mem_arr[21] = 32'h1234_5678;   // 0x54
    mem_arr[64] = 32'hAAAA_0001;   // 0x100

    // Reset values
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_i_stall", i_stall, 0);
    check("idle_d_stall", d_stall, 0);
    exp_d = '0;

    // Store with three wait cycles
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'd7; rsp_delay = 3;
    #1 check("st_stall0", d_stall, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("st_req", mem_req, 1);
      check("st_we", mem_we, 1);
      check("st_wdata", mem_wdata, 7);
      check("st_addr", mem_addr, 32'h54);
      check("st_stall", d_stall, 1);
    end
    @(negedge clk);
    check("st_done_stall", d_stall, 0);
    check("st_done_req", mem_req, 0);
    check("st_d_rdata", d_rdata, exp_d);
    check("st_mem", mem_arr[21], 7);
    d_req = 1'b0; d_we = 1'b0;

    // Lone fetch, ack on first mem_req cycle
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h40; rsp_delay = 0;
    #1 check("f_stall0", i_stall, 1);
    @(negedge clk);
    check("f_req", mem_req, 1);
    check("f_addr", mem_addr, 32'h40);
    check("f_we", mem_we, 0);
    check("f_stall1", i_stall, 1);
    @(negedge clk);
    exp_i = 32'h2008_0005;
    check("f_stall2", i_stall, 0);
    check("f_rdata", i_rdata, exp_i);
    check("f_req_drop", mem_req, 0);
    i_req = 1'b0;
    @(negedge clk);
    check("f_no_regrant", mem_req, 0);

    // Simultaneous requests, last grant was fetch: data first
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    i_req = 1'b1; i_addr = 32'h44;
    #1 check("sim_d_stall0", d_stall, 1);
    check("sim_i_stall0", i_stall, 1);
    @(negedge clk);
    check("sim_first_addr", mem_addr, 32'h100);
    @(negedge clk);
    exp_d = 32'hAAAA_0001;
    check("sim_d_done", d_stall, 0);
    check("sim_i_wait", i_stall, 1);
    check("sim_d_rdata", d_rdata, exp_d);
    d_req = 1'b0;
    @(negedge clk);
    check("sim_gap_req", mem_req, 0);
    check("sim_gap_i_stall", i_stall, 1);
    @(negedge clk);
    check("sim_i_req", mem_req, 1);
    check("sim_i_addr", mem_addr, 32'h44);
    @(negedge clk);
    exp_i = 32'h1111_0002;
    check("sim_i_done", i_stall, 0);
    check("sim_i_rdata", i_rdata, exp_i);
    i_req = 1'b0;

    // Fairness: data held for two loads with fetch pending -> D, I, D
    grant_q.delete();
    dn = 0; idone = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    i_req = 1'b1; i_addr = 32'h48;
    for (int c = 0; c < 30 && (dn < 2 || !idone); c++) begin
      @(negedge clk);
      if (d_req && !d_stall) begin
        exp_d = mem_arr[d_addr[10:2]];
        check("fair_d_rdata", d_rdata, exp_d);
        dn++;
        if (dn == 1) d_addr = 32'h108;
        else         d_req = 1'b0;
      end
      if (i_req && !i_stall) begin
        exp_i = mem_arr[i_addr[10:2]];
        check("fair_i_rdata", i_rdata, exp_i);
        idone = 1'b1;
        i_req = 1'b0;
      end
    end
    check("fair_complete", {31'd0, (dn == 2) && idone}, 1);
    check("fair_ngrants", grant_q.size(), 3);
    check("fair_g0", (grant_q.size() > 0) ? grant_q[0] : 32'hFFFF_FFFF, 32'h104);
    check("fair_g1", (grant_q.size() > 1) ? grant_q[1] : 32'hFFFF_FFFF, 32'h48);
    check("fair_g2", (grant_q.size() > 2) ? grant_q[2] : 32'hFFFF_FFFF, 32'h108);

    // Stray acks while idle are ignored
    @(negedge clk);
    spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    spur_ack = 1'b0;
    @(negedge clk);
    check("spur_i_rdata", i_rdata, exp_i);
    check("spur_d_rdata", d_rdata, exp_d);
    check("spur_req", mem_req, 0);

    // Fetch dropped mid-access still completes
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4C; rsp_delay = 2;
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);
    check("drop_req_held", mem_req, 1);
    @(negedge clk);
    @(negedge clk);
    exp_i = mem_arr[19];
    check("drop_i_rdata", i_rdata, exp_i);
    check("drop_req_low", mem_req, 0);
    check("drop_i_stall", i_stall, 0);

    // Reset during a data access
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10C; rsp_delay = 100;
    @(negedge clk);
    check("rma_req", mem_req, 1);
    #2 reset = 1'b1;
    #1 check("rma_async_drop", mem_req, 0);
    @(negedge clk);
    check("rma_addr", mem_addr, 0);
    check("rma_i_rdata", i_rdata, 0);
    check("rma_d_rdata", d_rdata, 0);
    check("rma_we", mem_we, 0);
    check("rma_err", err, 0);
    d_req = 1'b0; reset = 1'b0; rsp_delay = 0;
    exp_i = '0; exp_d = '0;
    @(negedge clk);
    check("rma_idle_req", mem_req, 0);
    check("rma_idle_stall", d_stall, 0);
    // last_d cleared by reset: simultaneous requests grant data first
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h110;
    i_req = 1'b1; i_addr = 32'h50;
    @(negedge clk);
    check("rma_first_addr", mem_addr, 32'h110);
    @(negedge clk);
    exp_d = mem_arr[68];
    check("rma_d_stall", d_stall, 0);
    check("rma_d_load", d_rdata, exp_d);
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    exp_i = mem_arr[20];
    check("rma_i_stall", i_stall, 0);
    check("rma_i_load", i_rdata, exp_i);
    i_req = 1'b0;

    // Randomised traffic against a unified-memory model
    @(negedge clk);
    for (int k = 0; k < 512; k++) ref_mem[k] = mem_arr[k];
    rsp_delay = -1;
    i_wait = 0; d_wait = 0; i_snap = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (c >= 600 && !i_req && !d_req) break;
      if (i_req && i_stall) i_wait++;
      if (d_req && d_stall) d_wait++;
      if (i_req && !i_stall) begin
        check("rnd_i_rdata", i_rdata, ref_mem[i_addr[10:2]]);
        check("rnd_i_fair", {31'd0, (d_grants - i_snap) <= 1}, 1);
        check("rnd_i_lat", {31'd0, i_wait <= 16}, 1);
        i_req = 1'b0;
      end
      if (d_req && !d_stall) begin
        if (d_we) begin
          check("rnd_st_keep", d_rdata, exp_d);
          ref_mem[d_addr[10:2]] = d_wdata;
        end else begin
          exp_d = ref_mem[d_addr[10:2]];
          check("rnd_ld_rdata", d_rdata, exp_d);
        end
        check("rnd_d_lat", {31'd0, d_wait <= 16}, 1);
        d_req = 1'b0;
      end
      if (c < 600 && !i_req && $urandom_range(1, 0) == 1) begin
        i_req  = 1'b1;
        i_addr = 32'($urandom_range(63, 0)) << 2;
        i_wait = 0;
        i_snap = d_grants;
      end
      if (c < 600 && !d_req && $urandom_range(1, 0) == 1) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(1, 0));
        d_addr  = 32'h100 | (32'($urandom_range(63, 0)) << 2);
        d_wdata = $urandom;
        d_wait  = 0;
      end
    end
    check("rnd_drained", {30'd0, i_req, d_req}, 0);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rsp_delay = 0;

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort after 16 mem_req cycles
    @(negedge clk);
    @(negedge clk);
    rsp_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h110;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("to_req", mem_req, 1);
      check("to_err_low", err, 0);
    end
    @(negedge clk);
    check("to_err", err, 1);
    check("to_d_rdata", d_rdata, 0);
    check("to_d_stall", d_stall, 0);
    check("to_req_drop", mem_req, 0);
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    check("to_sticky", err, 1);
    reset = 1'b1;
    @(negedge clk);
    check("to_err_rst", err, 0);
    reset = 1'b0;
    rsp_en = 1'b1;
`else
    @(negedge clk);
    check("err_tied", err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
